execute_cycle: RTL and testbench

- Execute (E) stage of the 5-stage RV32I pipeline; sits between the ID/EX register and the memory stage.
- Selects forwarded operands and computes the ALU result.
- Resolves branches and JAL, producing PCSrcE and PCTargetE for fetch.
- Owns the EX/MEM pipeline register that drives the memory stage's M-suffixed inputs.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/alu_unit.sv | 43 ++++
 rtl/execute_cycle.sv | 205 ++++++++++++++++++++
 tb/tb_execute_cycle.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the RV32I pipeline: ALU op codes, branch funct3 codes,
// forwarding selects and the multiplier FSM state type.
package pipe_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluAnd  = 3'b010;
  localparam logic [2:0] AluOr   = 3'b011;
  localparam logic [2:0] AluXor  = 3'b100;
  localparam logic [2:0] AluSlt  = 3'b101;
  localparam logic [2:0] AluMul  = 3'b110;
  localparam logic [2:0] AluSltu = 3'b111;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  localparam logic [1:0] FwdReg = 2'b00;
  localparam logic [1:0] FwdWb  = 2'b01;
  localparam logic [1:0] FwdMem = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } mul_state_e;

endpackage

// File: rtl/alu_unit.sv
// Combinational ALU plus branch comparison flags. The flags compare src_a
// against cmp_b (the forwarded register value), never against the immediate.
module alu_unit #(
  parameter int unsigned XLEN = pipe_pkg::XLEN
) (
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [XLEN-1:0] cmp_b,
  input  logic [2:0]      alu_op,
  output logic [XLEN-1:0] result,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);
  import pipe_pkg::*;

  logic slt_ab;
  logic sltu_ab;

  assign slt_ab  = $signed(src_a) < $signed(src_b);
  assign sltu_ab = src_a < src_b;

  always_comb begin
    result = '0;
    case (alu_op)
      AluAdd:  result = src_a + src_b;
      AluSub:  result = src_a - src_b;
      AluAnd:  result = src_a & src_b;
      AluOr:   result = src_a | src_b;
      AluXor:  result = src_a ^ src_b;
      AluSlt:  result = {{(XLEN-1){1'b0}}, slt_ab};
      AluSltu: result = {{(XLEN-1){1'b0}}, sltu_ab};
      // The product, when present, comes from the multiplier in the parent.
      AluMul:  result = '0;
      default: result = '0;
    endcase
  end

  assign eq  = src_a == cmp_b;
  assign lt  = $signed(src_a) < $signed(cmp_b);
  assign ltu = src_a < cmp_b;

endmodule

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and EX/MEM register.
// Define EXEC_MUL_EN to add an iterative shift-add MUL (ALUControlE=110) that stalls F/D/E.
module execute_cycle #(
  parameter int unsigned XLEN = pipe_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            ALUSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RD_E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            StallE
);
  import pipe_pkg::*;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] ex_result;
  logic            cmp_eq;
  logic            cmp_lt;
  logic            cmp_ltu;
  logic            branch_cond;
  logic            stall;

  // Select 11 falls through to the register-file value.
  always_comb begin
    src_a = RD1_E;
    case (ForwardA_E)
      FwdWb:   src_a = ResultW;
      FwdMem:  src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = RD2_E;
    case (ForwardB_E)
      FwdWb:   fwd_b = ResultW;
      FwdMem:  fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

  alu_unit #(
    .XLEN (XLEN)
  ) u_alu (
    .src_a  (src_a),
    .src_b  (src_b),
    .cmp_b  (fwd_b),
    .alu_op (ALUControlE),
    .result (alu_result),
    .eq     (cmp_eq),
    .lt     (cmp_lt),
    .ltu    (cmp_ltu)
  );

  always_comb begin
    branch_cond = 1'b0;
    case (Funct3E)
      F3Beq:   branch_cond = cmp_eq;
      F3Bne:   branch_cond = ~cmp_eq;
      F3Blt:   branch_cond = cmp_lt;
      F3Bge:   branch_cond = ~cmp_lt;
      F3Bltu:  branch_cond = cmp_ltu;
      F3Bgeu:  branch_cond = ~cmp_ltu;
      default: branch_cond = 1'b0;
    endcase
  end

  assign PCTargetE = PCE + Imm_Ext_E;
  assign PCSrcE    = ~stall & (JumpE | (BranchE & branch_cond));
  assign StallE    = stall;

`ifdef EXEC_MUL_EN
  localparam int unsigned CntW = $clog2(XLEN);

  mul_state_e      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CntW-1:0] count_q, count_d;
  logic            mul_done;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    stall    = 1'b0;
    mul_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (ALUControlE == AluMul && !FlushE) begin
          stall    = 1'b1;
          acc_d    = '0;
          mcand_d  = src_a;
          mplier_d = src_b;
          count_d  = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (FlushE) begin
          state_d = StIdle;
        end else begin
          stall = 1'b1;
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + 1'b1;
          if (count_q == CntW'(XLEN - 1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        mul_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  assign ex_result = mul_done ? acc_q : alu_result;
`else
  assign stall     = 1'b0;
  assign ex_result = alu_result;
`endif

  // Flush or stall loads a fully zeroed bubble so memory never sees a duplicate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else if (FlushE || stall) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= fwd_b;
      ALU_ResultM <= ex_result;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed self-checking bench for execute_cycle; the MUL scenarios build only
// when EXEC_MUL_EN is defined.
module tb_execute_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE;
  logic [2:0]  ALUControlE, Funct3E;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        FlushE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallE;

  int checks = 0;
  int errors = 0;

  execute_cycle dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteE   (RegWriteE),
    .MemWriteE   (MemWriteE),
    .ResultSrcE  (ResultSrcE),
    .BranchE     (BranchE),
    .JumpE       (JumpE),
    .ALUSrcE     (ALUSrcE),
    .ALUControlE (ALUControlE),
    .Funct3E     (Funct3E),
    .RD1_E       (RD1_E),
    .RD2_E       (RD2_E),
    .Imm_Ext_E   (Imm_Ext_E),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E),
    .RD_E        (RD_E),
    .ForwardA_E  (ForwardA_E),
    .ForwardB_E  (ForwardB_E),
    .ResultW     (ResultW),
    .FlushE      (FlushE),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .PCPlus4M    (PCPlus4M),
    .WriteDataM  (WriteDataM),
    .ALU_ResultM (ALU_ResultM),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .StallE      (StallE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; JumpE = 0; ALUSrcE = 0;
    ALUControlE = 3'b000; Funct3E = 3'b010;
    RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
    RD_E = 0; ForwardA_E = 0; ForwardB_E = 0; FlushE = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ResultSrcE = 1'($urandom);
      ALUControlE = 3'($urandom); RD1_E = $urandom; RD2_E = $urandom;
      Imm_Ext_E = $urandom; PCPlus4E = $urandom; RD_E = 5'($urandom);
      ForwardA_E = 2'($urandom); ForwardB_E = 2'($urandom); ResultW = $urandom;
      ALUSrcE = 1'($urandom); FlushE = 1'($urandom);
      step();
      checks++;
      if ({RegWriteM, MemWriteM, ResultSrcM, RD_M} !== 8'h00) begin
        errors++;
        $display("FAIL reset_ctrl: got %b expected 0", {RegWriteM, MemWriteM, ResultSrcM, RD_M});
      end
      checks++;
      if ({PCPlus4M, WriteDataM, ALU_ResultM} !== 96'h0) begin
        errors++;
        $display("FAIL reset_data: got %h %h %h expected 0", PCPlus4M, WriteDataM, ALU_ResultM);
      end
    end
    drive_nop();
    rst = 1'b1;
    ALUControlE = 3'b000; RD1_E = 5; RD2_E = 7; RD_E = 3; RegWriteE = 1; PCPlus4E = 32'h44;
    step();
    checks++;
    if (ALU_ResultM !== 32'd12) begin
      errors++; $display("FAIL first_add: got %0d expected 12", ALU_ResultM);
    end
    checks++;
    if (RD_M !== 5'd3 || RegWriteM !== 1'b1 || PCPlus4M !== 32'h44) begin
      errors++;
      $display("FAIL first_ctrl: got rd=%0d rw=%b pc4=%h expected 3 1 44", RD_M, RegWriteM, PCPlus4M);
    end
  endtask

  task automatic test_forwarding();
    drive_nop();
    ALUControlE = 3'b001; RD1_E = 10; RD2_E = 3;
    step();
    checks++;
    if (ALU_ResultM !== 32'd7) begin
      errors++; $display("FAIL fwd_sub: got %0d expected 7", ALU_ResultM);
    end
    drive_nop();
    ALUControlE = 3'b000; ForwardA_E = 2'b10; RD1_E = 32'h999; Imm_Ext_E = 1; ALUSrcE = 1;
    step();
    checks++;
    if (ALU_ResultM !== 32'd8) begin
      errors++; $display("FAIL fwd_mem_a: got %0d expected 8", ALU_ResultM);
    end
    drive_nop();
    ALUControlE = 3'b111; ForwardB_E = 2'b01; ResultW = 32'hFFFF_FFFF; RD2_E = 0; RD1_E = 0;
    step();
    checks++;
    if (ALU_ResultM !== 32'd1 || WriteDataM !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL fwd_wb_sltu: got %h wd=%h expected 1 ffffffff", ALU_ResultM, WriteDataM);
    end
    ALUControlE = 3'b101;
    step();
    checks++;
    if (ALU_ResultM !== 32'd0) begin
      errors++; $display("FAIL fwd_wb_slt: got %h expected 0", ALU_ResultM);
    end
    drive_nop();
    ALUControlE = 3'b000; ForwardA_E = 2'b11; ForwardB_E = 2'b11; RD1_E = 32'h50;
    RD2_E = 32'h5; ResultW = 32'h1000;
    step();
    checks++;
    if (ALU_ResultM !== 32'h55) begin
      errors++; $display("FAIL fwd_sel11: got %h expected 55", ALU_ResultM);
    end
  endtask

  task automatic test_alu_ops();
    logic [2:0]  ops [7];
    logic [31:0] as  [7];
    logic [31:0] bs  [7];
    logic [31:0] exp [7];
    ops = '{3'b010, 3'b011, 3'b100, 3'b001, 3'b000, 3'b101, 3'b110};
    as  = '{32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'h0, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 32'h3};
    bs  = '{32'h0FF0_00FF, 32'h0FF0_00FF, 32'h0FF0_00FF, 32'h1, 32'h2, 32'h1, 32'h4};
    exp = '{32'h00F0_0034, 32'hFFF0_12FF, 32'hFF00_12CB, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0};
`ifdef EXEC_MUL_EN
    for (int i = 0; i < 6; i++) begin
`else
    for (int i = 0; i < 7; i++) begin
`endif
      drive_nop();
      ALUControlE = ops[i]; RD1_E = as[i]; RD2_E = bs[i];
      step();
      checks++;
      if (ALU_ResultM !== exp[i]) begin
        errors++;
        $display("FAIL alu_op%b: got %h expected %h", ops[i], ALU_ResultM, exp[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3  [8];
    logic [31:0] a   [8];
    logic [31:0] b   [8];
    logic        br  [8];
    logic        jmp [8];
    logic        exp [8];
    f3  = '{3'b000, 3'b001, 3'b110, 3'b100, 3'b101, 3'b111, 3'b010, 3'b000};
    a   = '{32'd5, 32'd5, 32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd5};
    b   = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
            32'd5, 32'd6};
    br  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    jmp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive_nop();
      PCE = 32'h100; Imm_Ext_E = 32'h20; ALUSrcE = 1'b1;
      Funct3E = f3[i]; RD1_E = a[i]; RD2_E = b[i]; BranchE = br[i]; JumpE = jmp[i];
      #2;
      checks++;
      if (PCSrcE !== exp[i] || PCTargetE !== 32'h120) begin
        errors++;
        $display("FAIL branch%0d: got src=%b tgt=%h expected %b 120", i, PCSrcE, PCTargetE,
                 exp[i]);
      end
    end
    drive_nop();
    PCE = 32'hFFFF_FFF0; Imm_Ext_E = 32'h20;
    #2;
    checks++;
    if (PCTargetE !== 32'h10 || PCSrcE !== 1'b0) begin
      errors++; $display("FAIL target_wrap: got %h src=%b expected 10 0", PCTargetE, PCSrcE);
    end
    step();
  endtask

  task automatic test_flush();
    drive_nop();
    MemWriteE = 1; RegWriteE = 1; FlushE = 1; RD1_E = 1; RD2_E = 2; RD_E = 9;
    step();
    checks++;
    if (MemWriteM !== 1'b0 || RegWriteM !== 1'b0 || ALU_ResultM !== 32'h0) begin
      errors++;
      $display("FAIL flush_bubble: got mw=%b rw=%b res=%h expected 0 0 0", MemWriteM,
               RegWriteM, ALU_ResultM);
    end
    FlushE = 0;
    step();
    checks++;
    if (MemWriteM !== 1'b1 || RegWriteM !== 1'b1 || ALU_ResultM !== 32'd3 || RD_M !== 5'd9) begin
      errors++;
      $display("FAIL flush_resume: got mw=%b rw=%b res=%h rd=%0d expected 1 1 3 9", MemWriteM,
               RegWriteM, ALU_ResultM, RD_M);
    end
  endtask

  task automatic test_store();
    drive_nop();
    MemWriteE = 1; ALUSrcE = 1; Imm_Ext_E = 8; RD1_E = 32'h1000; RD2_E = 32'h1111_1111;
    ForwardB_E = 2'b01; ResultW = 32'hDEAD_BEEF;
    step();
    checks++;
    if (WriteDataM !== 32'hDEAD_BEEF || ALU_ResultM !== 32'h1008) begin
      errors++;
      $display("FAIL store: got wd=%h res=%h expected deadbeef 1008", WriteDataM, ALU_ResultM);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expv;
    expv = 32'h1008;
    for (int i = 0; i < 3; i++) begin
      drive_nop();
      ForwardA_E = 2'b10; ALUSrcE = 1; Imm_Ext_E = 32'h10; RD1_E = 32'h7777;
      expv = expv + 32'h10;
      step();
      checks++;
      if (ALU_ResultM !== expv) begin
        errors++; $display("FAIL b2b%0d: got %h expected %h", i, ALU_ResultM, expv);
      end
    end
`ifndef EXEC_MUL_EN
    checks++;
    if (StallE !== 1'b0) begin
      errors++; $display("FAIL no_stall: got %b expected 0", StallE);
    end
`endif
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul();
    int cnt;
    drive_nop();
    ALUControlE = 3'b110; RD1_E = 32'h12345; RD2_E = 32'h100; RegWriteE = 1; RD_E = 4;
    #1;
    cnt = 0;
    while (StallE === 1'b1 && cnt < 40) begin
      cnt++;
      step();
      checks++;
      if (RegWriteM !== 1'b0) begin
        errors++; $display("FAIL mul_bubble: got rw=%b expected 0", RegWriteM);
      end
    end
    checks++;
    if (cnt !== 33) begin
      errors++; $display("FAIL mul_stall_len: got %0d expected 33", cnt);
    end
    step();
    checks++;
    if (ALU_ResultM !== 32'h0123_4500 || RegWriteM !== 1'b1 || RD_M !== 5'd4) begin
      errors++;
      $display("FAIL mul_result: got %h rw=%b rd=%0d expected 01234500 1 4", ALU_ResultM,
               RegWriteM, RD_M);
    end
    drive_nop();
    step();
    ALUControlE = 3'b110; RD1_E = 32'h12345; RD2_E = 32'h100; RegWriteE = 1;
    for (int i = 0; i < 11; i++) step();
    drive_nop();
    FlushE = 1;
    step();
    FlushE = 0;
    #1;
    checks++;
    if (StallE !== 1'b0 || RegWriteM !== 1'b0) begin
      errors++; $display("FAIL mul_abort: got stall=%b rw=%b expected 0 0", StallE, RegWriteM);
    end
    step();
  endtask
`endif

  initial begin
    drive_nop();
    rst = 1'b0;
    #2;
    test_reset();
    test_forwarding();
    test_alu_ops();
    test_branch();
    test_flush();
    test_store();
    test_back_to_back();
`ifdef EXEC_MUL_EN
    test_mul();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
